clock_time_ctrl: RTL

//  Sequencer/controller for the digital clock's time-keeping datapath: sec/min/hour modulo counters.

---
 rtl/clock_pkg.sv | 39 +++
 rtl/clock_prescaler.sv | 40 ++++
 rtl/clock_time_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : clock_pkg                                                  |
// | Brief   : Shared mode encoding, field limits and helpers for the     |
// |           digital clock time-keeping controller.                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package clock_pkg;

  // Width of every time field presented to the display stage
  localparam int FIELD_W = 8;

  // Mode encoding as seen on the mode output
  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;

  // Highest legal seconds / minutes value
  localparam logic [FIELD_W-1:0] SEC_MAX = FIELD_W'(59);
  localparam logic [FIELD_W-1:0] MIN_MAX = FIELD_W'(59);

  // Controller states; the fourth code is never entered on purpose
  typedef enum logic [1:0] {
    ST_RUN     = MODE_RUN,
    ST_SET_HR  = MODE_SET_HR,
    ST_SET_MIN = MODE_SET_MIN,
    ST_UNUSED  = 2'd3
  } state_t;

  // Increment a field by one, wrapping to zero after max_val
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] value,
                                                  input logic [FIELD_W-1:0] max_val);
    return (value == max_val) ? '0 : value + FIELD_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_prescaler.sv
// +----------------------------------------------------------------------+
// | Module  : clock_prescaler                                            |
// | Brief   : Free-running modulo-TICK_DIV counter that emits a pulse on |
// |           the cycle it wraps; held at zero while run is low.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module clock_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // The wrap edge is the one on which the consumer advances, so tick is
  // combinational and lines up with the final count value.
  assign tick = run && (r_cnt == c_last);

  // Count while running, restart from zero on wrap or whenever stopped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_time_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : clock_time_ctrl                                            |
// | Brief   : Time-keeping sequencer: 1 Hz advance, sec->min->hour carry |
// |           chain and the button-driven time-set mode.                 |
// |           Optional feature macro: BLINK_EN (field blink strobe).     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOUR_MOD = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_btn,
  input  logic               inc_btn,
  output logic [FIELD_W-1:0] hour,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] sec,
  output logic [1:0]         mode,
  output logic               tick_1hz,
  output logic               blink
);

  localparam logic [FIELD_W-1:0] c_hour_max = FIELD_W'(HOUR_MOD - 1);

  state_t             r_state;
  logic [FIELD_W-1:0] r_hour;
  logic [FIELD_W-1:0] r_min;
  logic [FIELD_W-1:0] r_sec;
  logic               r_tick;
  logic               w_run;
  logic               w_tick;

  // Seconds only advance in RUN; set modes hold the prescaler at zero so
  // returning to RUN always gives a full second before the next tick.
  assign w_run = (r_state == ST_RUN);

  clock_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_div (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .tick  (w_tick)
  );

  // Mode sequencing, carry chain and field editing in one registered block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // A tick coinciding with mode_btn still lands before entering SET_HR
          if (w_tick) begin
            r_tick <= 1'b1;
            r_sec  <= wrap_inc(r_sec, SEC_MAX);
            if (r_sec == SEC_MAX) begin
              r_min <= wrap_inc(r_min, MIN_MAX);
              if (r_min == MIN_MAX) begin
                r_hour <= wrap_inc(r_hour, c_hour_max);
              end
            end
          end
          if (mode_btn) begin
            r_state <= ST_SET_HR;
          end
        end
        ST_SET_HR: begin
          // mode_btn wins over a simultaneous inc_btn
          if (mode_btn) begin
            r_state <= ST_SET_MIN;
          end else if (inc_btn) begin
            r_hour <= wrap_inc(r_hour, c_hour_max);
          end
        end
        ST_SET_MIN: begin
          // Leaving the set modes restarts the minute from second zero
          if (mode_btn) begin
            r_state <= ST_RUN;
            r_sec   <= '0;
          end else if (inc_btn) begin
            r_min <= wrap_inc(r_min, MIN_MAX);
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign hour     = r_hour;
  assign min      = r_min;
  assign sec      = r_sec;
  assign mode     = r_state;
  assign tick_1hz = r_tick;

`ifdef BLINK_EN
  logic w_blink_run;
  logic w_half_tick;
  logic r_blink;

  // Half-period counter runs only while a field is being edited; a mode
  // change stops it for one edge so every new field starts from phase 0.
  assign w_blink_run = ((r_state == ST_SET_HR) || (r_state == ST_SET_MIN)) && !mode_btn;

  clock_prescaler #(
    .TICK_DIV (TICK_DIV / 2)
  ) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .run   (w_blink_run),
    .tick  (w_half_tick)
  );

  // Toggle the blank strobe each half period, force it low otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink <= 1'b0;
    end else if (!w_blink_run) begin
      r_blink <= 1'b0;
    end else if (w_half_tick) begin
      r_blink <= ~r_blink;
    end
  end

  assign blink = r_blink;
`else
  assign blink = 1'b0;
`endif

endmodule

`default_nettype wire
